// File: rtl/ext_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ext_bridge
// Function : Turns cache external-port requests into 32-bit memory bus beats.
// Revision : 1.0 - initial release
// ============================================================================
module ext_bridge #(
   parameter int ILINE_BEATS = 8,
   parameter int DLINE_BEATS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        extreq,
   input  logic        extwr,
   input  logic [2:0]  extsz,
   input  logic [31:0] extaddr,
   input  logic [31:0] extwdata,
   output logic [31:0] extdata,
   output logic        extack,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_gnt,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid
);

   localparam int MAX_BEATS = (ILINE_BEATS > DLINE_BEATS) ? ILINE_BEATS : DLINE_BEATS;
   localparam int CNT_W     = $clog2(MAX_BEATS + 1);

   localparam logic [31:0] c_DW_MASK    = ~32'd7;
   localparam logic [31:0] c_DLINE_MASK = ~(32'(DLINE_BEATS * 4) - 32'd1);
   localparam logic [31:0] c_ILINE_MASK = ~(32'(ILINE_BEATS * 4) - 32'd1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_RWAIT = 3'd2,
      ST_ACK   = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              wr_q, wr_d;
   logic [31:0]       addr_q, addr_d;
   logic [CNT_W-1:0]  beats_q, beats_d;
   logic [3:0]        strb_q, strb_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [3:0]        wstrb_w;

   // Big-endian lanes: strobe bit 3 is byte offset 0.
   always_comb begin
      wstrb_w = 4'b1111;
      case (extsz)
         3'd0:    wstrb_w = 4'b1000 >> extaddr[1:0];
         3'd1:    wstrb_w = extaddr[1] ? 4'b0011 : 4'b1100;
         default: wstrb_w = 4'b1111;
      endcase
   end

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      beats_d = beats_q;
      strb_d  = strb_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (extreq) begin
               rdata_d = 32'd0;
               if (extsz <= 3'd5) begin
                  wr_d    = extwr;
                  strb_d  = extwr ? wstrb_w : 4'b1111;
                  state_d = ST_ISSUE;
                  case (extsz)
                     3'd3: begin
                        addr_d  = extaddr & c_DW_MASK;
                        beats_d = CNT_W'(2);
                     end
                     3'd4: begin
                        addr_d  = extaddr & c_DLINE_MASK;
                        beats_d = CNT_W'(DLINE_BEATS);
                     end
                     3'd5: begin
                        addr_d  = extaddr & c_ILINE_MASK;
                        beats_d = CNT_W'(ILINE_BEATS);
                     end
                     default: begin
                        addr_d  = {extaddr[31:2], 2'b00};
                        beats_d = CNT_W'(1);
                     end
                  endcase
               end else begin
                  // Reserved size: answer once with zero data, no bus traffic.
                  wr_d    = 1'b0;
                  beats_d = CNT_W'(1);
                  state_d = ST_ACK;
               end
            end
         end
         ST_ISSUE: begin
            if (mem_gnt) begin
               state_d = wr_q ? ST_ACK : ST_RWAIT;
            end
         end
         ST_RWAIT: begin
            if (mem_rvalid) begin
               rdata_d = mem_rdata;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            beats_d = beats_q - CNT_W'(1);
            if (beats_q > CNT_W'(1)) begin
               addr_d  = addr_q + 32'd4;
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_GAP;
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wr_q    <= 1'b0;
         addr_q  <= 32'd0;
         beats_q <= '0;
         strb_q  <= 4'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         beats_q <= beats_d;
         strb_q  <= strb_d;
         rdata_q <= rdata_d;
      end
   end

   assign extack    = (state_q == ST_ACK);
   assign extdata   = extack ? rdata_q : 32'd0;
   assign busy      = (state_q == ST_ISSUE) || (state_q == ST_RWAIT) || (state_q == ST_ACK);
   assign mem_req   = (state_q == ST_ISSUE);
   assign mem_we    = mem_req & wr_q;
   assign mem_addr  = mem_req ? addr_q : 32'd0;
   assign mem_wdata = mem_we ? extwdata : 32'd0;
   assign mem_wstrb = mem_req ? strb_q : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_ext_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_bridge
// Function : Directed self-checking bench for ext_bridge with a memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        extreq, extwr;
   logic [2:0]  extsz;
   logic [31:0] extaddr, extwdata, extdata;
   logic        extack, busy;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt, mem_rvalid;

   ext_bridge #(.ILINE_BEATS(8), .DLINE_BEATS(4)) dut (
      .clk(clk), .rst(rst),
      .extreq(extreq), .extwr(extwr), .extsz(extsz), .extaddr(extaddr),
      .extwdata(extwdata), .extdata(extdata), .extack(extack), .busy(busy),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   // Memory responder configuration and logs
   int          stall_beat = -1;
   int          stall_len  = 0;
   int          rv_delay   = 1;
   logic [31:0] rdata_base = 32'd0;
   int          wait_cnt   = 0;
   int          req_cycles = 0;
   int          stable_err = 0;
   bit          rv_pend    = 1'b0;
   int          rv_cnt     = 0;
   logic [31:0] rv_data    = 32'd0;
   logic [31:0] hold_addr, hold_wdata;
   logic [3:0]  hold_strb;
   logic        hold_we;

   logic [31:0] b_addr[$];
   logic [31:0] b_wdata[$];
   logic [3:0]  b_strb[$];
   logic        b_we[$];
   int          b_gcyc[$];
   logic [31:0] a_data[$];
   int          a_cyc[$];

   initial begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
      forever begin
         @(negedge clk);
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b0;
         if (rv_pend) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rv_data;
               rv_pend    = 1'b0;
            end
         end
         if (mem_req === 1'b1) begin
            req_cycles++;
            if (wait_cnt == 0) begin
               hold_addr  = mem_addr;
               hold_wdata = mem_wdata;
               hold_strb  = mem_wstrb;
               hold_we    = mem_we;
            end else if (mem_addr !== hold_addr || mem_wdata !== hold_wdata ||
                         mem_wstrb !== hold_strb || mem_we !== hold_we) begin
               stable_err++;
            end
            if (wait_cnt >= ((b_addr.size() == stall_beat) ? stall_len : 0)) begin
               mem_gnt = 1'b1;
               b_addr.push_back(mem_addr);
               b_wdata.push_back(mem_wdata);
               b_strb.push_back(mem_wstrb);
               b_we.push_back(mem_we);
               b_gcyc.push_back(cyc);
               if (!mem_we) begin
                  rv_pend = 1'b1;
                  rv_cnt  = rv_delay;
                  rv_data = rdata_base + 32'(b_addr.size() - 1);
               end
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (extack === 1'b1) begin
         a_data.push_back(extdata);
         a_cyc.push_back(cyc);
      end
   end

   task automatic clear_logs;
      b_addr.delete(); b_wdata.delete(); b_strb.delete(); b_we.delete(); b_gcyc.delete();
      a_data.delete(); a_cyc.delete();
      req_cycles = 0;
      stable_err = 0;
   endtask

   task automatic do_req(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input int n, input string tag);
      int k;
      tick;
      extreq = 1'b1; extwr = wr; extsz = sz; extaddr = addr; extwdata = wd;
      k = 0;
      while (a_data.size() < n && k < 300) begin
         tick;
         k++;
      end
      check_eq({tag, " ack count"}, a_data.size(), n);
      check_eq({tag, " busy at last ack"}, 32'(busy), 32'd1);
      extreq = 1'b0;
      tick;
      check_eq({tag, " busy after last ack"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int k;
      int n_ack;
      rst = 1'b1; extreq = 1'b0; extwr = 1'b0; extsz = 3'd0; extaddr = 32'd0; extwdata = 32'd0;
      repeat (3) tick;
      check_eq("reset extack", 32'(extack), 32'd0);
      check_eq("reset extdata", extdata, 32'd0);
      check_eq("reset busy", 32'(busy), 32'd0);
      check_eq("reset mem_req", 32'(mem_req), 32'd0);
      check_eq("reset mem_we", 32'(mem_we), 32'd0);
      check_eq("reset mem_addr", mem_addr, 32'd0);
      check_eq("reset mem_wdata", mem_wdata, 32'd0);
      check_eq("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
      rst = 1'b0;
      tick;

      // Byte write at offset 3
      clear_logs;
      do_req(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 1, "bw");
      check_eq("bw addr", b_addr[0], 32'h0000_1000);
      check_eq("bw strb", 32'(b_strb[0]), 32'h1);
      check_eq("bw wdata", b_wdata[0], 32'h0000_00AB);
      check_eq("bw we", 32'(b_we[0]), 32'd1);
      check_eq("bw ack latency", 32'(a_cyc[0] - b_gcyc[0]), 32'd1);

      // Halfword write in upper half of the word
      clear_logs;
      do_req(1'b1, 3'd1, 32'h0000_2003, 32'h0000_1234, 1, "hw");
      check_eq("hw addr", b_addr[0], 32'h0000_2000);
      check_eq("hw strb", 32'(b_strb[0]), 32'h3);

      // D-line fill, rvalid 2 cycles after each gnt
      clear_logs;
      rv_delay = 2;
      do_req(1'b0, 3'd4, 32'h0000_201C, 32'd0, 4, "dl");
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("dl addr%0d", i), b_addr[i], 32'h0000_2010 + 32'(4 * i));
         check_eq($sformatf("dl data%0d", i), a_data[i], 32'(i));
         check_eq($sformatf("dl lat%0d", i), 32'(a_cyc[i] - b_gcyc[i]), 32'd3);
      end
      check_eq("dl strb", 32'(b_strb[0]), 32'hF);
      check_eq("dl req cycles", 32'(req_cycles), 32'd4);

      // I-line fill with beat 3 stalled 5 cycles
      clear_logs;
      rv_delay   = 1;
      stall_beat = 3;
      stall_len  = 5;
      do_req(1'b0, 3'd5, 32'h0000_3014, 32'd0, 8, "il");
      for (int i = 0; i < 8; i++) begin
         check_eq($sformatf("il addr%0d", i), b_addr[i], 32'h0000_3000 + 32'(4 * i));
         check_eq($sformatf("il data%0d", i), a_data[i], 32'(i));
      end
      check_eq("il stall stable", 32'(stable_err), 32'd0);
      check_eq("il req cycles", 32'(req_cycles), 32'd13);
      check_eq("il stall gnt gap", 32'(b_gcyc[3] - b_gcyc[2]), 32'd8);
      stall_beat = -1;

      // Reserved size: single zero ack, no traffic
      clear_logs;
      do_req(1'b0, 3'd7, 32'h0000_0040, 32'd0, 1, "rsv");
      repeat (3) tick;
      check_eq("rsv data", a_data[0], 32'd0);
      check_eq("rsv single ack", a_data.size(), 32'd1);
      check_eq("rsv no req", 32'(req_cycles), 32'd0);

      // Reset during RWAIT of beat 2
      clear_logs;
      rv_delay = 4;
      tick;
      extreq = 1'b1; extwr = 1'b0; extsz = 3'd4; extaddr = 32'h0000_0500;
      k = 0;
      while (b_addr.size() < 2 && k < 100) begin
         tick;
         k++;
      end
      check_eq("rst beat2 granted", b_addr.size(), 32'd2);
      tick;
      rst = 1'b1;
      extreq = 1'b0;
      n_ack = a_data.size();
      tick;
      check_eq("rst acks before", 32'(n_ack), 32'd1);
      check_eq("rst extack", 32'(extack), 32'd0);
      check_eq("rst busy", 32'(busy), 32'd0);
      check_eq("rst mem_req", 32'(mem_req), 32'd0);
      check_eq("rst mem_addr", mem_addr, 32'd0);
      check_eq("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
      check_eq("rst extdata", extdata, 32'd0);
      rst = 1'b0;
      repeat (8) tick;
      check_eq("rst stale rvalid ignored", a_data.size(), 32'(n_ack));

      // 4B read after the reset
      clear_logs;
      rv_delay   = 1;
      rdata_base = 32'hA5A5_0000;
      do_req(1'b0, 3'd2, 32'h0000_0606, 32'd0, 1, "rd4");
      check_eq("rd4 addr", b_addr[0], 32'h0000_0604);
      check_eq("rd4 strb", 32'(b_strb[0]), 32'hF);
      check_eq("rd4 data", a_data[0], 32'hA5A5_0000);

      // 8B read
      clear_logs;
      rdata_base = 32'h1111_0000;
      do_req(1'b0, 3'd3, 32'h0000_0104, 32'd0, 2, "rd8");
      check_eq("rd8 addr0", b_addr[0], 32'h0000_0100);
      check_eq("rd8 addr1", b_addr[1], 32'h0000_0104);
      check_eq("rd8 strb0", 32'(b_strb[0]), 32'hF);
      check_eq("rd8 strb1", 32'(b_strb[1]), 32'hF);
      check_eq("rd8 data0", a_data[0], 32'h1111_0000);
      check_eq("rd8 data1", a_data[1], 32'h1111_0001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ext_bridge.md
Name: ext_bridge

Overview:
- Sits directly downstream of the cache block's external port (extreq/extwr/extsz/extdata/extack).
- Converts each cache miss, fill or uncached access into a sequence of 32-bit beats on the memory bus (mem_*).
- Returns read data to the cache one word per extack pulse.
- Handles big-endian byte-lane strobes for sub-word writes and multi-beat line fills.

Parameters:
- ILINE_BEATS, 8, beats for an instruction-line fill (32-byte line).
- DLINE_BEATS, 4, beats for a data-line fill or writeback (16-byte line).

Ports:
- clk  in  1  core clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- extreq  in  1  cache request; held high until the final extack of the transaction.
- extwr  in  1  1 = write, 0 = read; sampled with extreq in IDLE.
- extsz  in  3  0=1B, 1=2B, 2=4B, 3=8B, 4=D-line, 5=I-line, 6/7 reserved.
- extaddr  in  32  physical byte address; sampled in IDLE.
- extwdata  in  32  write word; cache updates it in the cycle after each write extack.
- extdata  out  32  read word; valid only while extack=1.
- extack  out  1  one-cycle pulse per completed beat.
- busy  out  1  high from acceptance until the cycle after the final extack.
- mem_req  out  1  beat request; held until mem_gnt.
- mem_we  out  1  beat is a write.
- mem_addr  out  32  word-aligned beat address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte enables; bit 3 = byte offset 0 (big-endian).
- mem_gnt  in  1  memory accepts the beat in any cycle where mem_req=1.
- mem_rdata  in  32  read data.
- mem_rvalid  in  1  read data valid; arrives 1 or more cycles after gnt.

Behaviour:
- Reset values: extack=0, extdata=0, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0. FSM goes to IDLE; beat counter is 0.
- States: IDLE, ISSUE, RWAIT, ACK, GAP.
- IDLE, extreq=1 with extsz 0..5: latch extwr, extsz, address and beat count, then go to ISSUE. Beats: sz 0..2 = 1, sz 3 = 2, sz 4 = DLINE_BEATS, sz 5 = ILINE_BEATS.
- Base address: sz 3 aligns down to 8; sz 4 aligns down to DLINE_BEATS*4; sz 5 aligns down to ILINE_BEATS*4; sz 0..2 use addr[31:2]. Each following beat adds +4. No wrap, no critical-word-first.
- IDLE, extsz 6/7: go to ACK with extdata=0. Issue no memory traffic.
- ISSUE drives mem_req=1, mem_we=wr, mem_addr, mem_wdata=extwdata and mem_wstrb.
  - Strobes for sz 0: 1000 >> addr[1:0].
  - Strobes for sz 1: addr[1]=0 gives 1100, addr[1]=1 gives 0011; addr[0] is ignored.
  - Strobes for all other sizes: 1111. Reads always drive 1111.
- mem_req and all mem_* outputs hold stable until gnt.
- Write beat, on gnt: extack=1 the next cycle (ACK).
- Read beat, on gnt: go to RWAIT.
  - mem_rvalid then registers extdata=mem_rdata with extack=1 in the next cycle.
  - Read latency to extack is the gnt-to-rvalid delay + 1.
- At most one beat is outstanding; mem_req=0 during RWAIT and ACK.
- ACK (one cycle): decrement the beat count. If beats remain, go to ISSUE with address +4; otherwise go to GAP.
- GAP: busy=0, and return to IDLE. A new request is accepted no earlier than 2 cycles after the final extack, so the cache can drop extreq.
- extreq dropping mid-transaction is ignored; the transaction completes.
- mem_rvalid outside RWAIT is ignored, including stale data after a reset.
- rst mid-transaction: next cycle all outputs are at reset values, the FSM is in IDLE, and the beat counter is cleared. No extack is emitted for the aborted transfer.
- Simultaneous mem_gnt and mem_rvalid in ISSUE: rvalid is ignored; only gnt counts.

Test Plan:
- Byte write: extsz=0, addr=0x00001003, extwr=1, extwdata=0x000000AB, gnt on first cycle -> one beat with mem_addr=0x00001000, mem_wstrb=0001, mem_wdata=0x000000AB; extack 1 cycle after gnt.
- D-line fill: extsz=4, addr=0x0000201C, rvalid 2 cycles after each gnt with rdata=beat index -> mem_addr 0x2010, 0x2014, 0x2018, 0x201C; four extack pulses with extdata 0..3; busy low one cycle after the last ack.
- I-line fill with gnt stalled 5 cycles on beat 3 -> mem_req and mem_addr=0x..0C held stable; 8 acks total, in order.
- Reserved size: extsz=7 -> single extack with extdata=0; mem_req never asserts.
- Reset mid-fill: rst during RWAIT of beat 2 -> outputs at reset values next cycle; a later rvalid produces no extack; a new 4B read afterwards completes normally.
- 8B read at addr 0x00000104 -> beats at 0x100 and 0x104; mem_wstrb=1111; two acks.
